// File: rtl/mem_sequencer_if.sv
// Shared single-port memory bus between the fetch/execute sequencer (master)
// and the memory slave.
interface mem_sequencer_if;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_busy;

  modport master (
    output bus_addr, bus_read, bus_write, bus_sel, bus_wdata,
    input  bus_rdata, bus_busy
  );

  modport slave (
    input  bus_addr, bus_read, bus_write, bus_sel, bus_wdata,
    output bus_rdata, bus_busy
  );
endinterface

// File: rtl/mem_sequencer.sv
// Fetch/execute sequencer and single-port memory controller: alternates
// instruction fetch and data load/store on one bus and pulses pc_enable once per instruction.
module mem_sequencer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        pc_enable,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_width,
  input  logic        d_unsigned,
  output logic [31:0] load,
  output logic        d_err,
  mem_sequencer_if.master bus
);

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DATA,
    S_RETIRE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   r_load;
  logic              r_err;
  logic              r_pc_enable;
  logic              r_d_err;
  logic              r_rd;
  logic              r_wr;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [1:0]        r_width;
  logic              r_unsigned;

  logic              w_err_next;
  logic              w_req_err;
  logic              w_done;
  logic              w_bus_read;
  logic              w_bus_write;
  logic [XLEN-1:0]   w_bus_addr;
  logic [3:0]        w_bus_sel;
  logic [XLEN-1:0]   w_bus_wdata;
  logic [3:0]        w_lane_sel;
  logic [XLEN-1:0]   w_lane_wdata;
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_load_ext;
  logic              w_unused_pc;

  assign w_unused_pc = ^pc[1:0];

  // Rejected data requests: conflicting strobes, illegal width or misalignment
  assign w_req_err = (d_read | d_write) &&
                     ((d_read && d_write) ||
                      (d_width == 2'b11) ||
                      (d_width == WIDTH_HALF && d_addr[0]) ||
                      (d_width == WIDTH_WORD && d_addr[1:0] != 2'b00));

  // Byte-lane steering for the sampled data request
  always_comb begin
    w_lane_sel   = 4'b1111;
    w_lane_wdata = r_wdata;
    case (r_width)
      WIDTH_BYTE: begin
        w_lane_sel   = 4'b0001 << r_addr[1:0];
        w_lane_wdata = {4{r_wdata[7:0]}};
      end
      WIDTH_HALF: begin
        w_lane_sel   = 4'b0011 << r_addr[1:0];
        w_lane_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_lane_sel   = 4'b1111;
        w_lane_wdata = r_wdata;
      end
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    w_lane     = bus.bus_rdata >> {r_addr[1:0], 3'b000};
    w_load_ext = bus.bus_rdata;
    case (r_width)
      WIDTH_BYTE: w_load_ext = r_unsigned ? {24'h0, w_lane[7:0]}
                                          : {{24{w_lane[7]}}, w_lane[7:0]};
      WIDTH_HALF: w_load_ext = r_unsigned ? {16'h0, w_lane[15:0]}
                                          : {{16{w_lane[15]}}, w_lane[15:0]};
      default:    w_load_ext = bus.bus_rdata;
    endcase
  end

  // Next-state and bus decode; bus outputs derive only from registered state
  always_comb begin
    w_next      = r_state;
    w_err_next  = r_err;
    w_done      = 1'b0;
    w_bus_read  = 1'b0;
    w_bus_write = 1'b0;
    w_bus_addr  = '0;
    w_bus_sel   = '0;
    w_bus_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_bus_read = 1'b1;
        w_bus_addr = {pc[31:2], 2'b00};
        w_bus_sel  = 4'b1111;
        w_done     = !bus.bus_busy;
        if (w_done) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_err_next = w_req_err;
        if (w_req_err)               w_next = S_RETIRE;
        else if (d_read || d_write)  w_next = S_DATA;
        else                         w_next = S_RETIRE;
      end
      S_DATA: begin
        w_bus_read  = r_rd;
        w_bus_write = r_wr;
        w_bus_addr  = {r_addr[31:2], 2'b00};
        w_bus_sel   = w_lane_sel;
        w_bus_wdata = r_wr ? w_lane_wdata : '0;
        w_done      = !bus.bus_busy;
        if (w_done) w_next = S_RETIRE;
      end
      S_RETIRE: begin
        w_err_next = 1'b0;
        w_next     = enable ? S_FETCH : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_instr     <= NOP_INSTR;
      r_load      <= '0;
      r_err       <= 1'b0;
      r_pc_enable <= 1'b0;
      r_d_err     <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_width     <= '0;
      r_unsigned  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_err       <= w_err_next;
      r_pc_enable <= (w_next == S_RETIRE);
      r_d_err     <= (w_next == S_RETIRE) && w_err_next;
      if (r_state == S_FETCH && w_done) r_instr <= bus.bus_rdata;
      if (r_state == S_EXEC) begin
        r_rd       <= d_read;
        r_wr       <= d_write;
        r_addr     <= d_addr;
        r_wdata    <= d_wdata;
        r_width    <= d_width;
        r_unsigned <= d_unsigned;
      end
      if (r_state == S_DATA && w_done && r_rd) r_load <= w_load_ext;
    end
  end

  assign instruction   = r_instr;
  assign load          = r_load;
  assign pc_enable     = r_pc_enable;
  assign d_err         = r_d_err;
  assign bus.bus_read  = w_bus_read;
  assign bus.bus_write = w_bus_write;
  assign bus.bus_addr  = w_bus_addr;
  assign bus.bus_sel   = w_bus_sel;
  assign bus.bus_wdata = w_bus_wdata;

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: scenario tasks with a load-result
// scoreboard filled at EXEC and drained at RETIRE.
module tb_mem_sequencer;

  logic        hz100 = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        pc_enable;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_width;
  logic        d_unsigned;
  logic [31:0] load;
  logic        d_err;

  mem_sequencer_if bif ();

  mem_sequencer #(.NOP_INSTR(32'h0000_0013)) dut (
    .hz100       (hz100),
    .reset       (reset),
    .enable      (enable),
    .pc          (pc),
    .instruction (instruction),
    .pc_enable   (pc_enable),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_width     (d_width),
    .d_unsigned  (d_unsigned),
    .load        (load),
    .d_err       (d_err),
    .bus         (bif.master)
  );

  always #5 hz100 = ~hz100;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_load;

  function automatic logic exp_err(input logic rd, input logic wr,
                                   input logic [1:0] w, input logic [31:0] a);
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (w == 2'b11) return 1'b1;
    if (w == 2'b01 && a[0]) return 1'b1;
    if (w == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b10) return 4'b1111;
    if (w == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    case (a[1:0])
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] w, input logic [31:0] wd);
    if (w == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (w == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] w, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    if (w == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
    if (w == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return rd;
  endfunction

  // One instruction from FETCH entry (caller is #1 after that edge) to just after RETIRE
  task automatic run_instr(input string name, input logic [31:0] instr,
                           input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] width,
                           input logic uns, input logic [31:0] rdata, input int busy_n);
    logic        err;
    logic        mem;
    logic [31:0] exp;
    logic [31:0] exp_wd;
    err = exp_err(rd, wr, width, addr);
    mem = (rd || wr) && !err;
    exp_wd = wr ? exp_wdata(width, wdata) : 32'h0;

    n_tests++;
    if (bif.bus_read !== 1'b1 || bif.bus_write !== 1'b0 ||
        bif.bus_addr !== {pc[31:2], 2'b00} || bif.bus_sel !== 4'b1111) begin
      n_fail++;
      $display("FAIL %s fetch: rd=%b wr=%b addr=%h sel=%b, required rd=1 wr=0 addr=%h sel=1111",
               name, bif.bus_read, bif.bus_write, bif.bus_addr, bif.bus_sel, {pc[31:2], 2'b00});
    end
    bif.bus_rdata = instr;
    bif.bus_busy  = 1'b0;
    @(posedge hz100); #1;

    n_tests++;
    if (instruction !== instr || bif.bus_read !== 1'b0 || bif.bus_write !== 1'b0 ||
        pc_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL %s exec: instr=%h rd=%b wr=%b pc_en=%b, required instr=%h rd=0 wr=0 pc_en=0",
               name, instruction, bif.bus_read, bif.bus_write, pc_enable, instr);
    end
    d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
    d_width = width; d_unsigned = uns;
    if (mem && rd) sb_q.push_back(exp_load(rdata, addr, width, uns));
    @(posedge hz100); #1;
    d_read = 1'b0; d_write = 1'b0;

    if (mem) begin
      for (int i = 0; i <= busy_n; i++) begin
        n_tests++;
        if (bif.bus_read !== rd || bif.bus_write !== wr ||
            bif.bus_addr !== {addr[31:2], 2'b00} || bif.bus_sel !== exp_sel(width, addr) ||
            bif.bus_wdata !== exp_wd || pc_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL %s data cyc%0d: rd=%b wr=%b addr=%h sel=%b wdata=%h pc_en=%b, required rd=%b wr=%b addr=%h sel=%b wdata=%h pc_en=0",
                   name, i, bif.bus_read, bif.bus_write, bif.bus_addr, bif.bus_sel,
                   bif.bus_wdata, pc_enable, rd, wr, {addr[31:2], 2'b00},
                   exp_sel(width, addr), exp_wd);
        end
        bif.bus_busy  = (i < busy_n);
        bif.bus_rdata = (i < busy_n) ? $urandom : rdata;
        @(posedge hz100); #1;
      end
      bif.bus_busy = 1'b0;
    end

    n_tests++;
    if (pc_enable !== 1'b1 || d_err !== err || bif.bus_read !== 1'b0 ||
        bif.bus_write !== 1'b0 || bif.bus_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s retire: pc_en=%b d_err=%b rd=%b wr=%b sel=%b, required pc_en=1 d_err=%b rd=0 wr=0 sel=0000",
               name, pc_enable, d_err, bif.bus_read, bif.bus_write, bif.bus_sel, err);
    end
    n_tests++;
    if (mem && rd) begin
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s load: scoreboard empty, load=%h", name, load);
      end else begin
        exp = sb_q.pop_front();
        model_load = exp;
        if (load !== exp) begin
          n_fail++;
          $display("FAIL %s load: got %h, required %h", name, load, exp);
        end
      end
    end else if (load !== model_load) begin
      n_fail++;
      $display("FAIL %s load held: got %h, required %h", name, load, model_load);
    end

    @(posedge hz100);
    pc = pc + 32'd4;
    #1;
    n_tests++;
    if (pc_enable !== 1'b0 || d_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post-retire: pc_en=%b d_err=%b, required 0 0", name, pc_enable, d_err);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_tests++;
    if (instruction !== 32'h0000_0013 || load !== 32'h0 || pc_enable !== 1'b0 ||
        d_err !== 1'b0 || bif.bus_read !== 1'b0 || bif.bus_write !== 1'b0 ||
        bif.bus_sel !== 4'b0000 || bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: instr=%h load=%h pc_en=%b d_err=%b rd=%b wr=%b sel=%b addr=%h wdata=%h, required 00000013 0 0 0 0 0 0000 0 0",
               name, instruction, load, pc_enable, d_err, bif.bus_read, bif.bus_write,
               bif.bus_sel, bif.bus_addr, bif.bus_wdata);
    end
  endtask

  task automatic test_reset();
    check_reset_vals("por");
    reset = 1'b0; enable = 1'b1; bif.bus_busy = 1'b1; bif.bus_rdata = 32'hDEAD_BEEF;
    @(posedge hz100); #1;
    n_tests++;
    if (bif.bus_read !== 1'b1 || bif.bus_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_fetch_entry: rd=%b addr=%h, required rd=1 addr=0", bif.bus_read, bif.bus_addr);
    end
    @(posedge hz100); #1;
    n_tests++;
    if (bif.bus_read !== 1'b1 || instruction !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL reset_fetch_stall: rd=%b instr=%h, required rd=1 instr=00000013",
               bif.bus_read, instruction);
    end
    reset = 1'b1;
    bif.bus_busy = 1'b0;
    @(posedge hz100); #1;
    bif.bus_busy = 1'b1;
    check_reset_vals("reset_edge1");
    @(posedge hz100); #1;
    check_reset_vals("reset_edge2");
    reset = 1'b0; bif.bus_busy = 1'b0;
    @(posedge hz100); #1;
  endtask

  task automatic test_addi();
    for (int i = 0; i < 3; i++)
      run_instr("addi", 32'h0010_0093, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 0);
  endtask

  task automatic test_lw_stall();
    run_instr("lw_stall", 32'h0000_a483, 1'b1, 1'b0, 32'h104, 32'h0, 2'b10, 1'b0,
              32'h0000_0001, 2);
  endtask

  task automatic test_sb();
    run_instr("sb", 32'h0090_01a3, 1'b0, 1'b1, 32'h203, 32'h1234_56A5, 2'b00, 1'b0, 32'h0, 1);
  endtask

  task automatic test_lb_lbu_lh();
    run_instr("lb",  32'h0010_0083, 1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 1'b0, 32'h0000_8000, 0);
    run_instr("lbu", 32'h0010_4083, 1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 1'b1, 32'h0000_8000, 0);
    run_instr("lh",  32'h0020_1083, 1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 32'h8001_0000, 0);
    run_instr("lhu", 32'h0020_5083, 1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 32'h8001_0000, 1);
  endtask

  task automatic test_misaligned();
    run_instr("lw_mis", 32'h0020_2083, 1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 32'hFFFF_FFFF, 0);
    run_instr("rdwr",   32'h0000_2083, 1'b1, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 32'hFFFF_FFFF, 0);
    run_instr("lh_mis", 32'h0010_1083, 1'b1, 1'b0, 32'h101, 32'h0, 2'b01, 1'b0, 32'hFFFF_FFFF, 0);
    run_instr("w11",    32'h0000_3083, 1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    run_instr("en_drop", 32'h0010_0093, 1'b0, 1'b1, 32'h300, 32'hCAFE_F00D, 2'b01, 1'b0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (bif.bus_read !== 1'b0 || bif.bus_write !== 1'b0 || pc_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold cyc%0d: rd=%b wr=%b pc_en=%b, required 0 0 0",
                 i, bif.bus_read, bif.bus_write, pc_enable);
      end
      @(posedge hz100); #1;
    end
    enable = 1'b1;
    @(posedge hz100); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      int          kind;
      logic        rd, wr;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      a  = 32'h1000 + 32'($urandom_range(0, 63));
      run_instr("b2b", $urandom, rd, wr, a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; pc = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    d_width = 2'b00; d_unsigned = 1'b0;
    bif.bus_rdata = 32'h0; bif.bus_busy = 1'b0;
    model_load = 32'h0;
    repeat (2) @(posedge hz100);
    #1;
    test_reset();
    test_addi();
    test_lw_stall();
    test_sb();
    test_lb_lbu_lh();
    test_misaligned();
    test_enable_drop();
    test_back_to_back();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Fetch/execute sequencer and single-port memory controller for the `cpu` core. It owns the one shared memory bus and performs instruction fetch and data load/store over it in turn. It generates `pc_enable` so the PC advances exactly once per retired instruction, which replaces the testbench-driven `pc_enable` stalls. It also handles byte/half/word lane steering, sign/zero extension and misalignment detection.

## Interface
Parameters:
- `NOP_INSTR`, 32'h0000_0013: instruction register value after reset (`addi x0,x0,0`).

Ports:
- `hz100`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  run permission; sequencer leaves IDLE only when high.
- `pc`  in  32  current PC from core.
- `instruction`  out  32  latched instruction, stable from EXEC through RETIRE.
- `pc_enable`  out  1  high for exactly the RETIRE cycle.
- `d_read`, `d_write`  in  1 each  data request from decode, valid in EXEC.
- `d_addr`  in  32  data byte address (ALU result).
- `d_wdata`  in  32  store data (rs2).
- `d_width`  in  2  funct3[1:0]: 00 byte, 01 half, 10 word; 11 illegal.
- `d_unsigned`  in  1  funct3[2]: zero-extend loads.
- `load`  out  32  extended load result, held until next completed load.
- `d_err`  out  1  high during RETIRE when the data request was rejected.
- `bus_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `bus_read`, `bus_write`  out  1 each  bus strobes; never both high.
- `bus_sel`  out  4  byte enables, bit i = byte lane i (little-endian).
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_rdata`  in  32  read data, valid on the completing edge.
- `bus_busy`  in  1  slave stall; a transfer completes on an edge where a strobe is high and `bus_busy`=0.

## Operation
- States: IDLE, FETCH, EXEC, DATA, RETIRE. All state and output registers update on the `hz100` rising edge.
- IDLE: all strobes 0. Moves to FETCH when `enable`=1.
- FETCH: `bus_read`=1, `bus_addr`={pc[31:2],2'b00}, `bus_sel`=1111. On completion, latch `bus_rdata` into `instruction` and go to EXEC.
- EXEC (1 cycle): sample `d_*` into internal registers.
  - `d_read`=1 and `d_write`=1, `d_width`=11, half with addr[0]=1, or word with addr[1:0]≠00: set the error flag and go to RETIRE. No bus access.
  - Otherwise, `d_read` or `d_write` high: go to DATA.
  - Neither high: go to RETIRE.
- DATA: drive the strobe from the sampled request.
  - `bus_sel`: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
  - `bus_wdata`: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - On read completion, select the lane from `bus_rdata` by addr[1:0], sign- or zero-extend per `d_unsigned`, and write the result to `load`.
  - On any completion, go to RETIRE.
- RETIRE (1 cycle): `pc_enable`=1 and `d_err`=error flag. Clear the error flag. Go to FETCH if `enable`=1, else IDLE.
- `enable` is examined only in IDLE and RETIRE. Dropping it elsewhere lets the current instruction finish.
- Stores never modify `load`. Rejected requests never modify `load`.

## Timing
- Reset values: state IDLE, `instruction`=NOP_INSTR, `load`=0, error flag 0. Therefore `pc_enable`, `d_err`, `bus_read`, `bus_write`=0, `bus_sel`=0000, `bus_addr`=0, `bus_wdata`=0.
- Strobes, `bus_addr`, `bus_sel` and `bus_wdata` are decoded from registered state only. They hold constant for every cycle `bus_busy`=1.
- Latency with `bus_busy`=0:
  - Non-memory instruction: FETCH 1 + EXEC 1 + RETIRE 1 = 3 cycles per `pc_enable` pulse.
  - Load/store: 4 cycles.
  - Each `bus_busy` cycle adds 1 cycle.
- The PC updates on the edge that ends RETIRE. The following FETCH uses the new `pc`.
- A strobe is never held across a state change. Bus address and data are never driven while their strobe is low.
- Reset asserted in any state, including mid-transfer with `bus_busy`=1: the next edge forces IDLE. Strobes drop in that cycle, and the pending transfer is abandoned with no register update.
- `load` and `instruction` change only on a completing edge.

## Test plan
- Reset: hold `reset`=1 for 2 edges from FETCH with `bus_busy`=1 -> all outputs at reset values, `instruction`=0x00000013, no strobe after the first edge.
- addi: `enable`=1, `pc`=0, `bus_busy`=0, `bus_rdata`=0x00100093, no `d_*` request -> `bus_read`=1 for 1 cycle at `bus_addr`=0; `instruction`=0x00100093; `pc_enable` pulses every 3 cycles.
- lw with stall: fetch 0x0000a483; in EXEC `d_read`=1, `d_addr`=0x104, `d_width`=10; `bus_busy`=1 for 2 cycles then 0 with `bus_rdata`=0x00000001 -> `bus_addr`=0x104, `bus_sel`=1111, `load`=0x00000001, `pc_enable` 6 cycles after FETCH entry.
- sb: `d_write`=1, `d_addr`=0x203, `d_width`=00, `d_wdata`=0x123456A5 -> `bus_addr`=0x200, `bus_sel`=1000, `bus_wdata`=0xA5A5A5A5, `load` unchanged.
- lb/lbu: `d_addr`=0x101, `bus_rdata`=0x00008000 -> `load`=0xFFFFFF80 with `d_unsigned`=0; `load`=0x00000080 with `d_unsigned`=1. lh at 0x102 with `bus_rdata`=0x80010000 -> `load`=0xFFFF8001.
- Misaligned/illegal: lw at `d_addr`=0x102, then `d_read`=`d_write`=1 -> no strobe in either case; `d_err`=1 and `pc_enable`=1 together in RETIRE; `load` unchanged.
